// File: rtl/dfb_spi_pkg.sv
// -----------------------------------------------------------------------------
// dfb_spi_pkg
// Shared definitions for the DFB1 expansion-header SPI master:
//   - register address constants (ID / CTRL / DATA / reserved)
//   - ID register value
//   - sequencer FSM state encoding
//   - helper that packs the CTRL read word
// -----------------------------------------------------------------------------
package dfb_spi_pkg;

    localparam logic [1:0] ADDR_ID   = 2'd0;
    localparam logic [1:0] ADDR_CTRL = 2'd1;
    localparam logic [1:0] ADDR_DATA = 2'd2;
    localparam logic [1:0] ADDR_RSVD = 2'd3;

    localparam logic [7:0] ID_VALUE  = 8'h01;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_LO   = 3'd2,
        ST_HI   = 3'd3,
        ST_DONE = 3'd4
    } spi_state_e;

    // CTRL read layout: {busy, 5'b0, slow, cs}
    function automatic logic [7:0] ctrl_word(input logic busy,
                                             input logic slow,
                                             input logic cs);
        return {busy, 5'b00000, slow, cs};
    endfunction

endpackage

// File: rtl/dfb_spi_master_if.sv
// -----------------------------------------------------------------------------
// dfb_spi_master_if
// Bundles the CPU register-strobe bus and the SPI pins of dfb_spi_master.
//   reg_stb/reg_rw/reg_addr/reg_wdata : register access from the F1DFBx decode
//   reg_rdata/reg_ack                 : read data and one-cycle acknowledge
//   busy                              : transfer in progress
//   spi_sclk/spi_mosi/spi_miso/spi_cs_n : expansion-header SPI pins
//   dbg_state                         : current sequencer state, for observation
// Modports:
//   master : the SPI master block itself
//   slave  : everything around it (CPU decode side and the SPI device side)
//
// Handshake: reg_stb is a single-cycle pulse with reg_rw/reg_addr/reg_wdata
// valid in the same cycle; the master always answers with reg_ack high for
// exactly the following cycle, with no back-pressure of any kind. reg_rdata is
// meaningful only while reg_ack is high and reads 8'hFF otherwise.
// -----------------------------------------------------------------------------
interface dfb_spi_master_if;
    import dfb_spi_pkg::*;

    logic        reg_stb;
    logic        reg_rw;
    logic [1:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        reg_ack;
    logic        busy;
    logic        spi_sclk;
    logic        spi_mosi;
    logic        spi_miso;
    logic        spi_cs_n;
    spi_state_e  dbg_state;

    modport master (
        input  reg_stb, reg_rw, reg_addr, reg_wdata, spi_miso,
        output reg_rdata, reg_ack, busy, spi_sclk, spi_mosi, spi_cs_n, dbg_state
    );

    modport slave (
        output reg_stb, reg_rw, reg_addr, reg_wdata, spi_miso,
        input  reg_rdata, reg_ack, busy, spi_sclk, spi_mosi, spi_cs_n, dbg_state
    );

endinterface

// File: rtl/spi_halfbit_timer.sv
// -----------------------------------------------------------------------------
// spi_halfbit_timer
// Loadable down-counter that times one SCLK half-period.
// Ports:
//   CLKOSC : clock, rising edge
//   RST    : asynchronous active-high reset
//   load   : while high, latch 'period' and preset the count to period-1
//   period : half-period length in CLKOSC cycles (>= 1)
//   tick   : high in the last cycle of each half-period; the counter reloads
//            to period-1 on the same edge
// The owner holds 'load' high whenever no bit is being clocked, so the counter
// only runs between SCLK edges and never free-runs.
// -----------------------------------------------------------------------------
module spi_halfbit_timer #(
    parameter int CNT_W = 8
) (
    input  logic             CLKOSC,
    input  logic             RST,
    input  logic             load,
    input  logic [CNT_W-1:0] period,
    output logic             tick
);

    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] count_q,  count_d;

    assign tick = !load && (count_q == '0);

    always_comb begin
        period_d = period_q;
        count_d  = count_q;
        if (load) begin
            period_d = period;
            count_d  = period - CNT_W'(1);
        end else if (count_q == '0) begin
            count_d  = period_q - CNT_W'(1);
        end else begin
            count_d  = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge CLKOSC or posedge RST) begin
        if (RST) begin
            period_q <= CNT_W'(1);
            count_q  <= '0;
        end else begin
            period_q <= period_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/dfb_spi_master.sv
// -----------------------------------------------------------------------------
// dfb_spi_master
// Register-mapped SPI master for the DFB1 expansion header. Runs 8-bit
// mode-0 transfers (SCLK idles low, MISO sampled on rising SCLK, MOSI changes
// on falling SCLK), MSB first, at a fast or slow half-period.
// Ports:
//   CLKOSC : system oscillator clock, all state on the rising edge
//   RST    : asynchronous active-high reset
//   bus    : dfb_spi_master_if.master (register bus, SPI pins, debug state)
// Registers:
//   0 ID   (R)  : 8'h01
//   1 CTRL (RW) : {busy,5'b0,slow,cs}; writes always accepted
//   2 DATA (RW) : read = last received byte; write when idle starts a transfer,
//                 write when busy is acknowledged but dropped
//   3 reserved  : reads 8'hFF, writes ignored
// -----------------------------------------------------------------------------
module dfb_spi_master
    import dfb_spi_pkg::*;
#(
    parameter int DIV_FAST = 1,
    parameter int DIV_SLOW = 50,
    parameter int CNT_W    = 8
) (
    input  logic               CLKOSC,
    input  logic               RST,
    dfb_spi_master_if.master   bus
);

    localparam logic [CNT_W-1:0] H_FAST = CNT_W'(DIV_FAST);
    localparam logic [CNT_W-1:0] H_SLOW = CNT_W'(DIV_SLOW);

    spi_state_e  state_q, state_d;
    logic [7:0]  tx_q, tx_d;
    logic [7:0]  rx_q, rx_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        slow_q, slow_d;
    logic        cs_q, cs_d;
    logic        ack_q, ack_d;
    logic [7:0]  rdata_q, rdata_d;

    logic             timer_load;
    logic [CNT_W-1:0] timer_period;
    logic             half_tick;

    logic        busy_w;
    logic        wr_stb;
    logic        rd_stb;
    logic        data_go;

    assign busy_w = (state_q != ST_IDLE);
    assign wr_stb = bus.reg_stb && !bus.reg_rw;
    assign rd_stb = bus.reg_stb &&  bus.reg_rw;
    // A DATA write is judged against busy in the strobe cycle, so one landing
    // in DONE is dropped even though the FSM is about to return to IDLE.
    assign data_go = wr_stb && (bus.reg_addr == ADDR_DATA) && (state_q == ST_IDLE);

    spi_halfbit_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .CLKOSC (CLKOSC),
        .RST    (RST),
        .load   (timer_load),
        .period (timer_period),
        .tick   (half_tick)
    );

    // Register decode and CTRL updates
    always_comb begin
        ack_d   = bus.reg_stb;
        rdata_d = 8'hFF;
        slow_d  = slow_q;
        cs_d    = cs_q;

        if (rd_stb) begin
            case (bus.reg_addr)
                ADDR_ID:   rdata_d = ID_VALUE;
                ADDR_CTRL: rdata_d = ctrl_word(busy_w, slow_q, cs_q);
                ADDR_DATA: rdata_d = rx_q;
                ADDR_RSVD: rdata_d = 8'hFF;
            endcase
        end

        if (wr_stb && (bus.reg_addr == ADDR_CTRL)) begin
            slow_d = bus.reg_wdata[1];
            cs_d   = bus.reg_wdata[0];
        end
    end

    // Sequencer next-state and datapath
    always_comb begin
        state_d      = state_q;
        tx_d         = tx_q;
        rx_d         = rx_q;
        bit_cnt_d    = bit_cnt_q;
        // Timer is held preset outside LO/HI; the value present during LOAD
        // is the one that governs the whole byte.
        timer_load   = 1'b1;
        timer_period = slow_q ? H_SLOW : H_FAST;

        case (state_q)
            ST_IDLE: begin
                if (data_go) begin
                    tx_d      = bus.reg_wdata;
                    bit_cnt_d = 3'd7;
                    state_d   = ST_LOAD;
                end
            end
            ST_LOAD: begin
                state_d = ST_LO;
            end
            ST_LO: begin
                timer_load = 1'b0;
                if (half_tick) begin
                    rx_d    = {rx_q[6:0], bus.spi_miso};
                    state_d = ST_HI;
                end
            end
            ST_HI: begin
                timer_load = 1'b0;
                if (half_tick) begin
                    if (bit_cnt_q == 3'd0) begin
                        state_d = ST_DONE;
                    end else begin
                        bit_cnt_d = bit_cnt_q - 3'd1;
                        state_d   = ST_LO;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLKOSC or posedge RST) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            tx_q      <= 8'hFF;
            rx_q      <= 8'hFF;
            bit_cnt_q <= 3'd7;
            slow_q    <= 1'b1;
            cs_q      <= 1'b1;
            ack_q     <= 1'b0;
            rdata_q   <= 8'hFF;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_q      <= rx_d;
            bit_cnt_q <= bit_cnt_d;
            slow_q    <= slow_d;
            cs_q      <= cs_d;
            ack_q     <= ack_d;
            rdata_q   <= rdata_d;
        end
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign bus.busy      = busy_w;
    assign bus.spi_sclk  = (state_q == ST_HI);
    // MOSI presents the current bit from LOAD onwards; bit_cnt only moves on
    // the HI->LO transition, i.e. on the falling SCLK edge.
    assign bus.spi_mosi  = ((state_q == ST_LOAD) || (state_q == ST_LO) || (state_q == ST_HI))
                           ? tx_q[bit_cnt_q] : 1'b1;
    // Chip select is purely software-driven; the sequencer never touches it.
    assign bus.spi_cs_n  = cs_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_dfb_spi_master.sv
// -----------------------------------------------------------------------------
// tb_dfb_spi_master
// Directed bench for dfb_spi_master with DIV_FAST=1, DIV_SLOW=50.
// A per-cycle sampler measures busy length and SCLK high-time per transfer;
// a SCLK monitor records MOSI at each rising edge into a stream that is
// compared with the expected MSB-first bit queue.
// -----------------------------------------------------------------------------
module tb_dfb_spi_master;
    import dfb_spi_pkg::*;

    logic CLKOSC;
    logic RST;

    dfb_spi_master_if bus ();

    dfb_spi_master #(
        .DIV_FAST (1),
        .DIV_SLOW (50),
        .CNT_W    (8)
    ) dut (
        .CLKOSC (CLKOSC),
        .RST    (RST),
        .bus    (bus)
    );

    // ---------------- clock / reset ----------------
    initial CLKOSC = 1'b0;
    always #5 CLKOSC = ~CLKOSC;

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // ---------------- SPI device model ----------------
    logic loop_en;
    logic miso_val;
    assign bus.spi_miso = loop_en ? bus.spi_mosi : miso_val;

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [0:0] exp_q[$];
    logic [0:0] obs_q[$];

    always @(posedge bus.spi_sclk) obs_q.push_back(bus.spi_mosi);

    // Per-transfer measurements, owned by the sampler only
    int busy_run = 0;
    int hi_run   = 0;
    int hi_min   = 0;
    int hi_max   = 0;
    int busy_prev = 0;
    int done_cnt = 0;
    int done_busy = 0;
    int done_hi_min = 0;
    int done_hi_max = 0;

    always begin
        @(posedge CLKOSC);
        #1;
        if (bus.busy) begin
            if (busy_prev == 0) begin
                busy_run = 0;
                hi_run   = 0;
                hi_min   = 32'h7FFF_FFFF;
                hi_max   = 0;
            end
            busy_run++;
            if (bus.spi_sclk) begin
                hi_run++;
            end else if (hi_run != 0) begin
                if (hi_run < hi_min) hi_min = hi_run;
                if (hi_run > hi_max) hi_max = hi_run;
                hi_run = 0;
            end
        end else if (busy_prev != 0) begin
            done_busy   = busy_run;
            done_hi_min = hi_min;
            done_hi_max = hi_max;
            done_cnt++;
        end
        busy_prev = bus.busy ? 1 : 0;
    end

    // ---------------- checking ----------------
    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
    endtask

    task automatic check_stream(input string tag);
        check_eq({tag, "_len"}, obs_q.size(), exp_q.size());
        while (exp_q.size() > 0 && obs_q.size() > 0)
            check_eq(tag, obs_q.pop_front(), exp_q.pop_front());
        obs_q.delete();
        exp_q.delete();
    endtask

    // ---------------- drivers ----------------
    // Strobe is asserted in the caller's current cycle; returns one cycle later
    // (the ack cycle) after checking the acknowledge.
    task automatic reg_write(input logic [1:0] addr, input logic [7:0] data);
        bus.reg_stb   = 1'b1;
        bus.reg_rw    = 1'b0;
        bus.reg_addr  = addr;
        bus.reg_wdata = data;
        @(posedge CLKOSC);
        #1;
        bus.reg_stb = 1'b0;
        check_eq("wr_ack", bus.reg_ack, 1'b1);
    endtask

    task automatic reg_read(input logic [1:0] addr, output logic [7:0] data);
        bus.reg_stb  = 1'b1;
        bus.reg_rw   = 1'b1;
        bus.reg_addr = addr;
        @(posedge CLKOSC);
        #1;
        bus.reg_stb = 1'b0;
        bus.reg_rw  = 1'b0;
        check_eq("rd_ack", bus.reg_ack, 1'b1);
        data = bus.reg_rdata;
        @(posedge CLKOSC);
        #1;
        check_eq("rd_ack_one", bus.reg_ack, 1'b0);
        check_eq("rd_idle_ff", bus.reg_rdata, 8'hFF);
    endtask

    task automatic wait_xfer(input int start, input int max_cycles);
        int n = 0;
        while (done_cnt == start && n < max_cycles) begin
            @(posedge CLKOSC);
            #2;
            n++;
        end
        check_eq("xfer_done", (done_cnt != start) ? 1 : 0, 1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [7:0] rd;
        int start;
        int n;

        RST = 1'b1;
        bus.reg_stb = 1'b0;
        bus.reg_rw = 1'b0;
        bus.reg_addr = 2'd0;
        bus.reg_wdata = 8'h00;
        loop_en = 1'b0;
        miso_val = 1'b0;
        repeat (3) @(posedge CLKOSC);
        #1;
        RST = 1'b0;

        // Reset state
        check_eq("rst_ack", bus.reg_ack, 1'b0);
        check_eq("rst_rdata", bus.reg_rdata, 8'hFF);
        check_eq("rst_busy", bus.busy, 1'b0);
        check_eq("rst_sclk", bus.spi_sclk, 1'b0);
        check_eq("rst_mosi", bus.spi_mosi, 1'b1);
        check_eq("rst_cs_n", bus.spi_cs_n, 1'b1);
        check_eq("rst_state", bus.dbg_state, ST_IDLE);
        reg_read(ADDR_ID, rd);   check_eq("rd_id", rd, 8'h01);
        reg_read(ADDR_CTRL, rd); check_eq("rd_ctrl_rst", rd, 8'h03);
        reg_read(ADDR_DATA, rd); check_eq("rd_data_rst", rd, 8'hFF);
        reg_read(ADDR_RSVD, rd); check_eq("rd_rsvd", rd, 8'hFF);

        // Fast A5, loopback
        reg_write(ADDR_CTRL, 8'h00);
        check_eq("cs_low", bus.spi_cs_n, 1'b0);
        loop_en = 1'b1;
        push_exp(8'hA5);
        start = done_cnt;
        reg_write(ADDR_DATA, 8'hA5);
        check_eq("busy_at_ack", bus.busy, 1'b1);
        wait_xfer(start, 100);
        check_eq("a5_busy_len", done_busy, 18);
        check_eq("a5_hi_max", done_hi_max, 1);
        check_stream("a5_mosi");
        reg_read(ADDR_DATA, rd); check_eq("a5_rx", rd, 8'hA5);

        // DATA write coincident with DONE is dropped
        push_exp(8'h11);
        reg_write(ADDR_DATA, 8'h11);
        repeat (17) begin @(posedge CLKOSC); #1; end
        check_eq("done_state", bus.dbg_state, ST_DONE);
        reg_write(ADDR_DATA, 8'h22);
        check_eq("done_wr_dropped", bus.busy, 1'b0);
        repeat (2) begin @(posedge CLKOSC); #1; end
        check_stream("x11_mosi");
        reg_read(ADDR_DATA, rd); check_eq("x11_rx", rd, 8'h11);

        // Slow 3C, miso tied low
        loop_en = 1'b0;
        miso_val = 1'b0;
        reg_write(ADDR_CTRL, 8'h02);
        push_exp(8'h3C);
        start = done_cnt;
        reg_write(ADDR_DATA, 8'h3C);
        wait_xfer(start, 2000);
        check_eq("slow_busy_len", done_busy, 802);
        check_eq("slow_hi_min", done_hi_min, 50);
        check_eq("slow_hi_max", done_hi_max, 50);
        check_stream("x3c_mosi");
        reg_read(ADDR_DATA, rd); check_eq("x3c_rx", rd, 8'h00);

        // DATA write while busy is acked but ignored
        loop_en = 1'b1;
        reg_write(ADDR_CTRL, 8'h00);
        push_exp(8'h5A);
        start = done_cnt;
        reg_write(ADDR_DATA, 8'h5A);
        repeat (2) begin @(posedge CLKOSC); #1; end
        reg_write(ADDR_DATA, 8'hFF);
        wait_xfer(start, 100);
        check_eq("x5a_busy_len", done_busy, 18);
        check_stream("x5a_mosi");
        reg_read(ADDR_DATA, rd); check_eq("x5a_rx", rd, 8'h5A);

        // Slow selected mid-transfer: current byte stays fast, next is slow
        push_exp(8'hC3);
        start = done_cnt;
        reg_write(ADDR_DATA, 8'hC3);
        repeat (4) begin @(posedge CLKOSC); #1; end
        reg_write(ADDR_CTRL, 8'h02);
        wait_xfer(start, 100);
        check_eq("mid_busy_len", done_busy, 18);
        check_eq("mid_hi_max", done_hi_max, 1);
        check_stream("xc3_mosi");
        push_exp(8'h81);
        start = done_cnt;
        reg_write(ADDR_DATA, 8'h81);
        reg_read(ADDR_CTRL, rd); check_eq("rd_ctrl_busy", rd, 8'h82);
        wait_xfer(start, 2000);
        check_eq("next_busy_len", done_busy, 802);
        check_eq("next_hi_min", done_hi_min, 50);
        check_stream("x81_mosi");
        reg_read(ADDR_DATA, rd); check_eq("x81_rx", rd, 8'h81);

        // Reset at the 4th rising SCLK
        reg_write(ADDR_CTRL, 8'h00);
        obs_q.delete();
        reg_write(ADDR_DATA, 8'h96);
        n = 0;
        while (obs_q.size() < 4 && n < 100) begin
            @(posedge CLKOSC);
            #1;
            n++;
        end
        check_eq("fourth_rise_seen", obs_q.size(), 4);
        RST = 1'b1;
        #1;
        check_eq("mid_rst_sclk", bus.spi_sclk, 1'b0);
        check_eq("mid_rst_cs_n", bus.spi_cs_n, 1'b1);
        check_eq("mid_rst_busy", bus.busy, 1'b0);
        check_eq("mid_rst_mosi", bus.spi_mosi, 1'b1);
        @(posedge CLKOSC);
        #1;
        check_eq("mid_rst_state", bus.dbg_state, ST_IDLE);
        check_eq("mid_rst_sclk2", bus.spi_sclk, 1'b0);
        RST = 1'b0;
        obs_q.delete();
        reg_read(ADDR_DATA, rd); check_eq("mid_rst_rx", rd, 8'hFF);
        reg_read(ADDR_CTRL, rd); check_eq("mid_rst_ctrl", rd, 8'h03);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
